// File: rtl/sgdmac_engine.sv
// Scatter-gather DMA engine: walks a linked list of 4-word descriptors and
// copies each descriptor's payload one 32-bit word at a time.
module sgdmac_engine #(
    parameter int LEN_W      = 16,
    parameter int DESC_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] start_pointer_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DREQ  = 3'd1;
    localparam logic [2:0] S_DWAIT = 3'd2;
    localparam logic [2:0] S_RREQ  = 3'd3;
    localparam logic [2:0] S_RWAIT = 3'd4;
    localparam logic [2:0] S_WREQ  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;

    localparam logic [1:0]       LAST_IDX = 2'(DESC_WORDS - 1);
    localparam logic [LEN_W-1:0] WORD_LEN = LEN_W'(4);

    logic [2:0]       state_q, state_d;
    logic [31:0]      desc_ptr_q, desc_ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [29:0]      next_addr_q, next_addr_d;
    logic             last_q, last_d;
    logic [31:0]      buf_q, buf_d;

    assign done_o = (state_q == S_IDLE);

    // Request outputs are pure functions of registered state, so they stay
    // stable for as long as the FSM waits for a grant.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_DREQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = desc_ptr_q + {28'd0, idx_q, 2'b00};
            end
            S_RREQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = src_q;
            end
            S_WREQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = dst_q;
                mem_wdata_o = buf_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        desc_ptr_d  = desc_ptr_q;
        idx_d       = idx_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        next_addr_d = next_addr_q;
        last_d      = last_q;
        buf_d       = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    desc_ptr_d = start_pointer_i;
                    idx_d      = 2'd0;
                    state_d    = S_DREQ;
                end
            end
            S_DREQ: begin
                if (mem_gnt_i) state_d = S_DWAIT;
            end
            S_DWAIT: begin
                if (mem_rvalid_i) begin
                    case (idx_q)
                        2'd0:    src_d = mem_rdata_i;
                        2'd1:    dst_d = mem_rdata_i;
                        2'd2:    len_d = {mem_rdata_i[LEN_W-1:2], 2'b00};
                        default: begin
                            next_addr_d = mem_rdata_i[31:2];
                            last_d      = mem_rdata_i[0];
                        end
                    endcase
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_DREQ;
                    end else begin
                        // len was captured at idx 2, so it is already valid here
                        state_d = (len_q != '0) ? S_RREQ : S_NEXT;
                    end
                end
            end
            S_RREQ: begin
                if (mem_gnt_i) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (mem_rvalid_i) begin
                    buf_d   = mem_rdata_i;
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                if (mem_gnt_i) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    len_d   = len_q - WORD_LEN;
                    state_d = (len_q != WORD_LEN) ? S_RREQ : S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_q) begin
                    state_d = S_IDLE;
                end else begin
                    desc_ptr_d = {next_addr_q, 2'b00};
                    idx_d      = 2'd0;
                    state_d    = S_DREQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            desc_ptr_q  <= '0;
            idx_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            next_addr_q <= '0;
            last_q      <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            desc_ptr_q  <= desc_ptr_d;
            idx_q       <= idx_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            next_addr_q <= next_addr_d;
            last_q      <= last_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_sgdmac_engine.sv
// Scoreboard bench for sgdmac_engine: a list-walking reference model predicts
// every memory access; a monitor checks each granted access against it.
module tb_sgdmac_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] start_pointer_i = '0;
    logic        start_i = 1'b0;
    logic        done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    sgdmac_engine #(.LEN_W(16), .DESC_WORDS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_pointer_i(start_pointer_i),
        .start_i        (start_i),
        .done_o         (done_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int          tests = 0;
    int          fails = 0;
    int          max_stall = 0;
    int          hit300 = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] w2, input logic [31:0] w3);
        put(a, s);
        put(a + 4, d);
        put(a + 8, w2);
        put(a + 12, w3);
    endtask

    task automatic fill(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) put(a + 32'(4 * i), $urandom);
    endtask

    // Reference model: walk the list in ref_mem and predict every access in order.
    task automatic build_expect(input logic [31:0] start);
        logic [31:0] p, s, d, nx, w;
        int          len;
        p = start;
        for (int n = 0; n < 64; n++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, p + 32'(4 * i), 32'd0});
            s   = rd_ref(p);
            d   = rd_ref(p + 4);
            len = int'(rd_ref(p + 8) & 32'h0000_FFFC);
            nx  = rd_ref(p + 12);
            while (len > 0) begin
                w = rd_ref(s);
                exp_q.push_back('{1'b0, s, 32'd0});
                exp_q.push_back('{1'b1, d, w});
                ref_mem[d] = w;
                s   = s + 4;
                d   = d + 4;
                len = len - 4;
            end
            if (nx[0]) break;
            p = nx & 32'hFFFF_FFFC;
        end
    endtask

    // Memory responder: random grant stalls, one pending read, random read latency.
    initial begin
        int          stall = 0;
        bit          pend = 0;
        int          pcnt = 0;
        logic [31:0] paddr = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rd_mem(paddr);
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_gnt_i = 1'b1;
                    if (mem_addr_o[31:4] == 28'h000_0030) hit300++;
                    if (mem_we_o) begin
                        mem[mem_addr_o] = mem_wdata_o;
                    end else begin
                        pend  = 1;
                        paddr = mem_addr_o;
                        pcnt  = $urandom_range(0, max_stall);
                    end
                    stall = $urandom_range(0, max_stall);
                end
            end else if (max_stall != 0) begin
                mem_gnt_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: protocol rules plus in-order comparison against the scoreboard.
    initial begin
        bit          hold = 0;
        bit          outst = 0;
        logic [31:0] h_addr = '0, h_wdata = '0;
        logic        h_we = 1'b0;
        acc_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold)
                    check(mem_req_o && mem_we_o == h_we && mem_addr_o == h_addr && mem_wdata_o == h_wdata,
                          "req_held_until_gnt", mem_addr_o, h_addr);
                if (mem_req_o && outst) check(1'b0, "second_outstanding_read", mem_addr_o, 32'd0);
                if (mem_req_o && mem_gnt_i) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_access", mem_addr_o, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check(mem_we_o == e.we, "acc_we", 32'(mem_we_o), 32'(e.we));
                        check(mem_addr_o == e.addr, "acc_addr", mem_addr_o, e.addr);
                        if (e.we) check(mem_wdata_o == e.data, "acc_wdata", mem_wdata_o, e.data);
                    end
                    if (!mem_we_o) outst = 1;
                end
                hold   = mem_req_o && !mem_gnt_i;
                h_we   = mem_we_o;
                h_addr = mem_addr_o;
                h_wdata = mem_wdata_o;
            end
            if (mem_rvalid_i) outst = 0;
        end
    end

    task automatic pulse_start(input logic [31:0] p, input bit chk_busy);
        @(negedge clk);
        start_pointer_i = p;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (chk_busy) begin
            #2;
            check(done_o == 1'b0, "done_low_after_start", 32'(done_o), 32'd0);
        end
    endtask

    task automatic wait_done(input int maxc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!done_o && n < maxc);
        check(done_o == 1'b1, name, 32'(done_o), 32'd1);
    endtask

    task automatic end_test(input string name, input bit memchk);
        check(exp_q.size() == 0, name, 32'(exp_q.size()), 32'd0);
        if (memchk)
            foreach (ref_mem[k]) check(rd_mem(k) == ref_mem[k], "mem_contents", rd_mem(k), ref_mem[k]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check(done_o == 1'b1, "rst_done", 32'(done_o), 32'd1);
        check(mem_req_o == 1'b0, "rst_req", 32'(mem_req_o), 32'd0);
        check(mem_we_o == 1'b0, "rst_we", 32'(mem_we_o), 32'd0);
        check(mem_addr_o == 32'd0, "rst_addr", mem_addr_o, 32'd0);
        check(mem_wdata_o == 32'd0, "rst_wdata", mem_wdata_o, 32'd0);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;

        // Single LAST descriptor, 4 words, no stalls
        put_desc(32'h100, 32'h1000, 32'h2000, 32'd16, 32'h1);
        fill(32'h1000, 4);
        build_expect(32'h100);
        pulse_start(32'h100, 1);
        wait_done(500, "t1_done");
        end_test("t1_drained", 1);

        // Chain of two, 8 bytes each
        put_desc(32'h100, 32'h1100, 32'h2100, 32'd8, 32'h200);
        put_desc(32'h200, 32'h1200, 32'h2200, 32'd8, 32'h1);
        fill(32'h1100, 2);
        fill(32'h1200, 2);
        build_expect(32'h100);
        pulse_start(32'h100, 1);
        wait_done(500, "t2_done");
        end_test("t2_drained", 1);

        // Zero-length LAST descriptor; upper word2 bits must be ignored
        put_desc(32'h180, 32'h1300, 32'h2300, 32'hABCD_0003, 32'h1);
        build_expect(32'h180);
        pulse_start(32'h180, 1);
        wait_done(500, "t3_done");
        end_test("t3_drained", 1);

        // Random chains under backpressure
        max_stall = 5;
        for (int it = 0; it < 4; it++) begin
            int          nd;
            logic [31:0] da, sa, ta, w2, w3;
            int          len;
            nd = $urandom_range(1, 3);
            for (int d = 0; d < nd; d++) begin
                da  = 32'h4000 + 32'(it * 32'h100 + d * 32'h20);
                sa  = 32'h10000 + 32'(it * 32'h1000 + d * 32'h100);
                ta  = 32'h20000 + 32'(it * 32'h1000 + d * 32'h100);
                len = $urandom_range(0, 60);
                w2  = ($urandom & 32'hFFFF_0000) | 32'(len);
                w3  = (d == nd - 1) ? (32'h1 | ($urandom & 32'h2))
                                    : ((da + 32'h20) | ($urandom & 32'h2));
                put_desc(da, sa, ta, w2, w3);
                fill(sa, len / 4 + 1);
            end
            build_expect(32'h4000 + 32'(it * 32'h100));
            pulse_start(32'h4000 + 32'(it * 32'h100), 1);
            wait_done(3000, "t4_done");
            end_test("t4_drained", 1);
        end

        // start while busy must be ignored
        hit300 = 0;
        put_desc(32'h100, 32'h1400, 32'h2400, 32'd32, 32'h1);
        fill(32'h1400, 8);
        build_expect(32'h100);
        pulse_start(32'h100, 1);
        repeat (15) @(negedge clk);
        pulse_start(32'h300, 0);
        wait_done(3000, "t5_done");
        end_test("t5_drained", 1);
        check(hit300 == 0, "t5_no_0x300_access", 32'(hit300), 32'd0);

        // Asynchronous reset mid-copy, then a clean restart
        put_desc(32'h100, 32'h1500, 32'h2500, 32'd64, 32'h1);
        fill(32'h1500, 16);
        build_expect(32'h100);
        pulse_start(32'h100, 1);
        repeat (25) @(negedge clk);
        #3;
        check(done_o == 1'b0, "t6_busy_before_reset", 32'(done_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check(mem_req_o == 1'b0, "t6_req_in_reset", 32'(mem_req_o), 32'd0);
        check(done_o == 1'b1, "t6_done_in_reset", 32'(done_o), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check(exp_q.size() == 0, "t6_quiet_after_reset", 32'(exp_q.size()), 32'd0);
        ref_mem = mem;
        put_desc(32'h600, 32'h1600, 32'h2600, 32'd12, 32'h1);
        fill(32'h1600, 3);
        build_expect(32'h600);
        pulse_start(32'h600, 1);
        wait_done(3000, "t6_done");
        end_test("t6_drained", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
